mem_ctrl: RTL and testbench

//  Memory-side responder for the fetcher's instruction-fetch port and the LSB's load/store port.

---
 rtl/mem_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: turns word fetches and 1/2/4-byte loads/stores
// into a sequence of single-byte RAM/IO bus cycles, one byte per clock.
module mem_ctrl #(
  parameter logic [31:0] IO_ADDR_LO = 32'h30000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        en_signal_from_if,
  input  logic [31:0] pc_from_if,
  input  logic        drop_flag_from_if,
  output logic [31:0] inst_to_if,
  output logic        ok_flag_to_if,
  input  logic        en_signal_from_lsb,
  input  logic        rw_flag_from_lsb,
  input  logic [31:0] addr_from_lsb,
  input  logic [2:0]  size_from_lsb,
  input  logic [31:0] data_from_lsb,
  output logic [31:0] data_to_lsb,
  output logic        ok_flag_to_lsb,
  input  logic        rollback_flag_from_rob
);

  typedef enum logic [1:0] {IDLE, IF_READ, LS_READ, LS_WRITE} state_t;

  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n, len, len_n;
  logic [31:0] base, base_n, wdata, wdata_n, rbuf, rbuf_n;
  logic        if_pend, if_pend_n;
  logic [31:0] if_pc, if_pc_n;
  logic        ls_pend, ls_pend_n, ls_rw, ls_rw_n;
  logic [31:0] ls_addr, ls_addr_n, ls_data, ls_data_n;
  logic [2:0]  ls_len, ls_len_n, req_len;
  logic [31:0] mem_a_n, inst_n, data_n;
  logic [7:0]  mem_dout_n, wr_byte;
  logic        mem_wr_n, ok_if_n, ok_lsb_n;
  logic [31:0] cur_addr, read_word;
  logic        io_stall;

  assign cur_addr = base + {29'd0, cnt};
  assign io_stall = (cur_addr >= IO_ADDR_LO) && io_buffer_full;

  always_comb begin
    case (size_from_lsb)
      3'd1:    req_len = 3'd1;
      3'd2:    req_len = 3'd2;
      default: req_len = 3'd4;
    endcase
  end

  // The byte arriving now belongs to the address driven one cycle earlier (index cnt-1).
  always_comb begin
    read_word = rbuf;
    case (cnt)
      3'd1:    read_word[7:0]   = mem_din;
      3'd2:    read_word[15:8]  = mem_din;
      3'd3:    read_word[23:16] = mem_din;
      default: read_word[31:24] = mem_din;
    endcase
  end

  always_comb begin
    case (cnt[1:0])
      2'd0:    wr_byte = wdata[7:0];
      2'd1:    wr_byte = wdata[15:8];
      2'd2:    wr_byte = wdata[23:16];
      default: wr_byte = wdata[31:24];
    endcase
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    len_n      = len;
    base_n     = base;
    wdata_n    = wdata;
    rbuf_n     = rbuf;
    if_pend_n  = if_pend;
    if_pc_n    = if_pc;
    ls_pend_n  = ls_pend;
    ls_rw_n    = ls_rw;
    ls_addr_n  = ls_addr;
    ls_data_n  = ls_data;
    ls_len_n   = ls_len;
    mem_a_n    = mem_a;
    mem_dout_n = mem_dout;
    mem_wr_n   = mem_wr;
    inst_n     = inst_to_if;
    data_n     = data_to_lsb;
    ok_if_n    = 1'b0;
    ok_lsb_n   = 1'b0;

    case (state)
      IDLE: begin
        if (ls_pend && !(rollback_flag_from_rob && !ls_rw)) begin
          ls_pend_n = 1'b0;
          base_n    = ls_addr;
          len_n     = ls_len;
          wdata_n   = ls_data;
          rbuf_n    = '0;
          mem_a_n   = ls_addr;
          if (ls_rw) begin
            state_n = LS_WRITE;
            if (ls_addr >= IO_ADDR_LO && io_buffer_full) begin
              cnt_n    = 3'd0;
              mem_wr_n = 1'b0;
            end else begin
              cnt_n      = 3'd1;
              mem_dout_n = ls_data[7:0];
              mem_wr_n   = 1'b1;
            end
          end else begin
            state_n  = LS_READ;
            cnt_n    = 3'd1;
            mem_wr_n = 1'b0;
          end
        end else if (if_pend && !drop_flag_from_if) begin
          state_n   = IF_READ;
          if_pend_n = 1'b0;
          base_n    = if_pc;
          len_n     = 3'd4;
          rbuf_n    = '0;
          cnt_n     = 3'd1;
          mem_a_n   = if_pc;
          mem_wr_n  = 1'b0;
        end
      end
      IF_READ, LS_READ: begin
        if ((state == IF_READ && drop_flag_from_if) ||
            (state == LS_READ && rollback_flag_from_rob)) begin
          state_n  = IDLE;
          mem_a_n  = '0;
          mem_wr_n = 1'b0;
        end else if (cnt == len) begin
          state_n  = IDLE;
          mem_a_n  = '0;
          mem_wr_n = 1'b0;
          if (state == IF_READ) begin
            inst_n  = read_word;
            ok_if_n = 1'b1;
          end else begin
            data_n   = read_word;
            ok_lsb_n = 1'b1;
          end
        end else begin
          rbuf_n  = read_word;
          mem_a_n = cur_addr;
          cnt_n   = cnt + 3'd1;
        end
      end
      LS_WRITE: begin
        if (cnt == len) begin
          state_n  = IDLE;
          mem_a_n  = '0;
          mem_wr_n = 1'b0;
          ok_lsb_n = 1'b1;
        end else if (io_stall) begin
          mem_wr_n = 1'b0;
        end else begin
          mem_a_n    = cur_addr;
          mem_dout_n = wr_byte;
          mem_wr_n   = 1'b1;
          cnt_n      = cnt + 3'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    // A fresh request overrides the acceptance clear above; drop/rollback override both.
    if (en_signal_from_if) begin
      if_pend_n = 1'b1;
      if_pc_n   = pc_from_if;
    end
    if (drop_flag_from_if) if_pend_n = 1'b0;
    if (en_signal_from_lsb) begin
      ls_pend_n = 1'b1;
      ls_rw_n   = rw_flag_from_lsb;
      ls_addr_n = addr_from_lsb;
      ls_data_n = data_from_lsb;
      ls_len_n  = req_len;
    end
    if (rollback_flag_from_rob && !ls_rw_n) ls_pend_n = 1'b0;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state          <= IDLE;
      cnt            <= '0;
      len            <= '0;
      base           <= '0;
      wdata          <= '0;
      rbuf           <= '0;
      if_pend        <= 1'b0;
      if_pc          <= '0;
      ls_pend        <= 1'b0;
      ls_rw          <= 1'b0;
      ls_addr        <= '0;
      ls_data        <= '0;
      ls_len         <= '0;
      mem_a          <= '0;
      mem_dout       <= '0;
      mem_wr         <= 1'b0;
      inst_to_if     <= '0;
      data_to_lsb    <= '0;
      ok_flag_to_if  <= 1'b0;
      ok_flag_to_lsb <= 1'b0;
    end else if (rdy_in) begin
      state          <= state_n;
      cnt            <= cnt_n;
      len            <= len_n;
      base           <= base_n;
      wdata          <= wdata_n;
      rbuf           <= rbuf_n;
      if_pend        <= if_pend_n;
      if_pc          <= if_pc_n;
      ls_pend        <= ls_pend_n;
      ls_rw          <= ls_rw_n;
      ls_addr        <= ls_addr_n;
      ls_data        <= ls_data_n;
      ls_len         <= ls_len_n;
      mem_a          <= mem_a_n;
      mem_dout       <= mem_dout_n;
      mem_wr         <= mem_wr_n;
      inst_to_if     <= inst_n;
      data_to_lsb    <= data_n;
      ok_flag_to_if  <= ok_if_n;
      ok_flag_to_lsb <= ok_lsb_n;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a byte RAM model answers bus reads, and a scoreboard
// of expected writes / ok pulses is checked whenever the controller produces them.
module tb_mem_ctrl;

  logic        clk_in, rst_in, rdy_in;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;
  logic        en_signal_from_if, drop_flag_from_if, ok_flag_to_if;
  logic [31:0] pc_from_if, inst_to_if;
  logic        en_signal_from_lsb, rw_flag_from_lsb, ok_flag_to_lsb, rollback_flag_from_rob;
  logic [31:0] addr_from_lsb, data_from_lsb, data_to_lsb;
  logic [2:0]  size_from_lsb;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t         wrQ[$];
  logic [31:0] ifQ[$];
  logic [32:0] lsbQ[$];
  int          total = 0;
  int          bad = 0;
  time         ifTime, lsbTime;
  logic [7:0]  ram [0:262143];

  mem_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .en_signal_from_if(en_signal_from_if), .pc_from_if(pc_from_if),
    .drop_flag_from_if(drop_flag_from_if), .inst_to_if(inst_to_if),
    .ok_flag_to_if(ok_flag_to_if),
    .en_signal_from_lsb(en_signal_from_lsb), .rw_flag_from_lsb(rw_flag_from_lsb),
    .addr_from_lsb(addr_from_lsb), .size_from_lsb(size_from_lsb),
    .data_from_lsb(data_from_lsb), .data_to_lsb(data_to_lsb),
    .ok_flag_to_lsb(ok_flag_to_lsb), .rollback_flag_from_rob(rollback_flag_from_rob)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic applyIf(input logic [31:0] pc);
    en_signal_from_if = 1'b1;
    pc_from_if = pc;
    tick();
    en_signal_from_if = 1'b0;
  endtask

  task automatic applyLsb(input logic rw, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] data);
    en_signal_from_lsb = 1'b1;
    rw_flag_from_lsb = rw;
    addr_from_lsb = addr;
    size_from_lsb = size;
    data_from_lsb = data;
    tick();
    en_signal_from_lsb = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n = 0;
    while ((ifQ.size() + lsbQ.size() + wrQ.size()) != 0 && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, ifQ.size() + lsbQ.size() + wrQ.size(), 32'd0);
    ifQ.delete();
    lsbQ.delete();
    wrQ.delete();
  endtask

  // RAM model and scoreboard consumer, sampled on the falling edge.
  initial begin
    wr_t        w;
    logic [32:0] e;
    for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
    ram[18'h00100] = 8'h13; ram[18'h00101] = 8'h05;
    ram[18'h00200] = 8'h37; ram[18'h00201] = 8'h12;
    ram[18'h3FFFE] = 8'h11; ram[18'h3FFFF] = 8'h22;
    ram[18'h00000] = 8'h33; ram[18'h00001] = 8'h44;
    mem_din = 8'h00;
    forever begin
      @(negedge clk_in);
      if (mem_wr) begin
        ram[mem_a[17:0]] = mem_dout;
        if (wrQ.size() == 0) checkOutput("strayWrite", {31'd0, mem_wr}, 32'd0);
        else begin
          w = wrQ.pop_front();
          checkOutput("wrAddr", mem_a, w.addr);
          checkOutput("wrData", {24'd0, mem_dout}, {24'd0, w.data});
        end
      end
      mem_din = ram[mem_a[17:0]];
      if (ok_flag_to_if) begin
        ifTime = $time;
        if (ifQ.size() == 0) checkOutput("strayOkIf", {31'd0, ok_flag_to_if}, 32'd0);
        else checkOutput("instToIf", inst_to_if, ifQ.pop_front());
      end
      if (ok_flag_to_lsb) begin
        lsbTime = $time;
        if (lsbQ.size() == 0) checkOutput("strayOkLsb", {31'd0, ok_flag_to_lsb}, 32'd0);
        else begin
          e = lsbQ.pop_front();
          if (e[32]) checkOutput("dataToLsb", data_to_lsb, e[31:0]);
        end
      end
    end
  end

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0;
    en_signal_from_if = 1'b0; pc_from_if = '0; drop_flag_from_if = 1'b0;
    en_signal_from_lsb = 1'b0; rw_flag_from_lsb = 1'b0; addr_from_lsb = '0;
    size_from_lsb = '0; data_from_lsb = '0; rollback_flag_from_rob = 1'b0;
    tick(); tick();
    checkOutput("rstMemWr", {31'd0, mem_wr}, 32'd0);
    checkOutput("rstMemA", mem_a, 32'd0);
    checkOutput("rstOkIf", {31'd0, ok_flag_to_if}, 32'd0);
    checkOutput("rstOkLsb", {31'd0, ok_flag_to_lsb}, 32'd0);
    checkOutput("rstInst", inst_to_if, 32'd0);
    checkOutput("rstData", data_to_lsb, 32'd0);
    rst_in = 1'b1;
    tick();

    // Reset asserted in the middle of a 4-byte store.
    wrQ.push_back('{32'h500, 8'h44});
    applyLsb(1'b1, 32'h500, 3'd4, 32'h11223344);
    tick(); tick();
    rst_in = 1'b0;
    #1;
    checkOutput("midRstMemWr", {31'd0, mem_wr}, 32'd0);
    checkOutput("midRstMemA", mem_a, 32'd0);
    checkOutput("midRstDout", {24'd0, mem_dout}, 32'd0);
    tick();
    rst_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("postRstMemWr", {31'd0, mem_wr}, 32'd0);
    end
    waitDone("rstDrain", 4);

    // Word fetch with per-cycle address check.
    ifQ.push_back(32'h00000513);
    applyIf(32'h100);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("fetchAddr", mem_a, 32'h100 + k);
    end
    tick();
    checkOutput("fetchOk", {31'd0, ok_flag_to_if}, 32'd1);
    checkOutput("fetchInst", inst_to_if, 32'h00000513);
    tick();
    checkOutput("fetchOkPulse", {31'd0, ok_flag_to_if}, 32'd0);
    waitDone("fetchDrain", 4);

    // Halfword store, then loads of it.
    wrQ.push_back('{32'h1FFE, 8'hDD});
    wrQ.push_back('{32'h1FFF, 8'hCC});
    lsbQ.push_back({1'b0, 32'h0});
    applyLsb(1'b1, 32'h1FFE, 3'd2, 32'hAABBCCDD);
    tick();
    checkOutput("st0Addr", mem_a, 32'h1FFE);
    checkOutput("st0Wr", {31'd0, mem_wr}, 32'd1);
    tick();
    checkOutput("st1Addr", mem_a, 32'h1FFF);
    checkOutput("st1Dout", {24'd0, mem_dout}, 32'hCC);
    tick();
    checkOutput("stOk", {31'd0, ok_flag_to_lsb}, 32'd1);
    checkOutput("stDoneWr", {31'd0, mem_wr}, 32'd0);
    waitDone("storeDrain", 4);
    lsbQ.push_back({1'b1, 32'h000000CC});
    applyLsb(1'b0, 32'h1FFF, 3'd1, 32'h0);
    waitDone("loadB", 10);
    lsbQ.push_back({1'b1, 32'h0000CCDD});
    applyLsb(1'b0, 32'h1FFE, 3'd2, 32'h0);
    waitDone("loadH", 10);
    lsbQ.push_back({1'b1, 32'h00000513});
    applyLsb(1'b0, 32'h100, 3'd3, 32'h0);
    waitDone("loadOddSize", 12);
    lsbQ.push_back({1'b1, 32'h44332211});
    applyLsb(1'b0, 32'hFFFFFFFE, 3'd4, 32'h0);
    waitDone("loadWrap", 12);

    // Simultaneous requests: LSB first, IF afterwards.
    lsbQ.push_back({1'b1, 32'h000000CC});
    ifQ.push_back(32'h00000513);
    en_signal_from_if = 1'b1;
    pc_from_if = 32'h100;
    applyLsb(1'b0, 32'h1FFF, 3'd1, 32'h0);
    en_signal_from_if = 1'b0;
    waitDone("bothDrain", 20);
    checkOutput("lsbBeforeIf", {31'd0, lsbTime < ifTime}, 32'd1);

    // Drop during fetch at cnt=2, then a clean re-request.
    applyIf(32'h100);
    tick(); tick();
    drop_flag_from_if = 1'b1;
    tick();
    drop_flag_from_if = 1'b0;
    checkOutput("dropMemA", mem_a, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("dropNoOk", {31'd0, ok_flag_to_if}, 32'd0);
    end
    en_signal_from_if = 1'b1;
    pc_from_if = 32'h100;
    drop_flag_from_if = 1'b1;
    tick();
    en_signal_from_if = 1'b0;
    drop_flag_from_if = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("dropSameCyc", mem_a, 32'd0);
    end
    ifQ.push_back(32'h00001237);
    applyIf(32'h200);
    waitDone("refetch", 12);

    // Rollback aborts a load but not a store.
    applyLsb(1'b0, 32'h100, 3'd4, 32'h0);
    tick(); tick();
    rollback_flag_from_rob = 1'b1;
    tick();
    rollback_flag_from_rob = 1'b0;
    checkOutput("rbMemA", mem_a, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("rbNoOk", {31'd0, ok_flag_to_lsb}, 32'd0);
    end
    for (int k = 0; k < 4; k++) wrQ.push_back('{32'h600 + k, 8'(8'h04 - k)});
    lsbQ.push_back({1'b0, 32'h0});
    applyLsb(1'b1, 32'h600, 3'd4, 32'h01020304);
    tick(); tick();
    rollback_flag_from_rob = 1'b1;
    tick();
    rollback_flag_from_rob = 1'b0;
    waitDone("rbStore", 12);

    // Freeze mid-fetch.
    ifQ.push_back(32'h00001237);
    applyIf(32'h200);
    tick(); tick();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("frozenMemA", mem_a, 32'h201);
    end
    rdy_in = 1'b1;
    waitDone("freezeFetch", 12);

    // IO store held off while the IO buffer is full.
    io_buffer_full = 1'b1;
    wrQ.push_back('{32'h30000, 8'h5A});
    lsbQ.push_back({1'b0, 32'h0});
    applyLsb(1'b1, 32'h30000, 3'd1, 32'h0000005A);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("ioStallWr", {31'd0, mem_wr}, 32'd0);
    end
    io_buffer_full = 1'b0;
    tick();
    checkOutput("ioWr", {31'd0, mem_wr}, 32'd1);
    checkOutput("ioAddr", mem_a, 32'h30000);
    tick();
    checkOutput("ioOk", {31'd0, ok_flag_to_lsb}, 32'd1);
    waitDone("ioDrain", 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
